// File: rtl/hex_entry_register.sv
// -----------------------------------------------------------------------------
// hex_entry_register
//
// Purpose:
//   Keypad-style hex entry. The operator sets a hex digit on four switches and
//   uses three active-low push-buttons to append the digit (push), remove the
//   most recent digit (del) or clear everything (clr). Every button goes
//   through a 2-flop synchronizer, a counter-based debouncer and a falling-edge
//   detector, so one physical press gives exactly one action. Digits are
//   shifted nibble-wise into a 32-bit register that feeds the display stage.
//
// Optional feature (macro HOLD_REPEAT_EN):
//   When defined, holding push issues an extra push every REPEAT_CYCLES
//   cycles after the press. When undefined, one push per press.
//
// Parameters:
//   DEBOUNCE_CYCLES  cycles a synchronized level must disagree with the
//                    debounced state before that state flips
//   REPEAT_CYCLES    auto-repeat period (only used with HOLD_REPEAT_EN)
//
// Ports:
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   digit_in     hex digit from switches (asynchronous to clk)
//   push_n       active-low button: append digit_in
//   del_n        active-low button: remove last digit
//   clr_n        active-low button: clear all
//   register     entered value, bits [3:0] hold the most recent digit
//   digit_count  number of digits entered, 0..8
//   full         digit_count == 8 (combinational)
//   overflow     sticky flag: push attempted while full (cleared by clr)
// -----------------------------------------------------------------------------
module hex_entry_register #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned REPEAT_CYCLES   = 25000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  digit_in,
  input  logic        push_n,
  input  logic        del_n,
  input  logic        clr_n,
  output logic [31:0] register,
  output logic [3:0]  digit_count,
  output logic        full,
  output logic        overflow
);

  // Debounce counter only has to reach DEBOUNCE_CYCLES-1.
  localparam int unsigned     DB_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  localparam int BTN_PUSH = 0;
  localparam int BTN_DEL  = 1;
  localparam int BTN_CLR  = 2;
  localparam int NUM_BTN  = 3;

  // Both periods must be at least one cycle; a zero period has no meaning.
  if ((DEBOUNCE_CYCLES == 0) || (REPEAT_CYCLES == 0)) begin : g_bad_param
    $error("hex_entry_register: DEBOUNCE_CYCLES and REPEAT_CYCLES must be >= 1");
  end

  // ---------------------------------------------------------------------------
  // Button conditioning: synchronize, debounce, detect press (1 -> 0)
  // ---------------------------------------------------------------------------
  logic [NUM_BTN-1:0] btn_n;
  logic [NUM_BTN-1:0] press_stb;

  assign btn_n = {clr_n, del_n, push_n};

`ifdef HOLD_REPEAT_EN
  logic push_held;
`endif

  genvar gi;
  generate
    for (gi = 0; gi < NUM_BTN; gi++) begin : g_btn
      logic            sync1_q;
      logic            sync2_q;
      logic            stable_q;
      logic            stable_d;
      logic            stable_dly_q;
      logic [DB_W-1:0] db_cnt_q;
      logic [DB_W-1:0] db_cnt_d;

      // Everything resets to "released" so a button held through reset is
      // seen as a fresh press once the debounce time has elapsed.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          sync1_q      <= 1'b1;
          sync2_q      <= 1'b1;
          stable_q     <= 1'b1;
          stable_dly_q <= 1'b1;
          db_cnt_q     <= '0;
        end else begin
          sync1_q      <= btn_n[gi];
          sync2_q      <= sync1_q;
          stable_q     <= stable_d;
          stable_dly_q <= stable_q;
          db_cnt_q     <= db_cnt_d;
        end
      end

      // The counter only advances while the synchronized level disagrees with
      // the debounced state; any agreeing cycle restarts it, so a glitch
      // shorter than DEBOUNCE_CYCLES never flips the state.
      always_comb begin
        stable_d = stable_q;
        db_cnt_d = '0;
        if (sync2_q != stable_q) begin
          if (db_cnt_q == DB_LAST) begin
            stable_d = sync2_q;
          end else begin
            db_cnt_d = db_cnt_q + DB_W'(1);
          end
        end
      end

      // One-cycle strobe in the first cycle the debounced level reads pressed.
      assign press_stb[gi] = stable_dly_q & ~stable_q;

`ifdef HOLD_REPEAT_EN
      if (gi == BTN_PUSH) begin : g_hold
        assign push_held = ~stable_q;
      end
`endif
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Digit synchronizer
  // ---------------------------------------------------------------------------
  logic [3:0] dig_sync1_q;
  logic [3:0] dig_sync2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dig_sync1_q <= '0;
      dig_sync2_q <= '0;
    end else begin
      dig_sync1_q <= digit_in;
      dig_sync2_q <= dig_sync1_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Push event source (press strobe, optionally plus auto-repeat)
  // ---------------------------------------------------------------------------
  logic push_evt;

`ifdef HOLD_REPEAT_EN
  localparam int unsigned     RP_W    = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
  localparam logic [RP_W-1:0] RP_LAST = RP_W'(REPEAT_CYCLES - 1);

  logic [RP_W-1:0] rpt_cnt_q;
  logic [RP_W-1:0] rpt_cnt_d;
  logic            rpt_fire;

  assign rpt_fire = push_held && (rpt_cnt_q == RP_LAST);

  // The period restarts from every strobe (press, del, clr, or a repeat) and
  // is held at zero while push is released.
  always_comb begin
    rpt_cnt_d = rpt_cnt_q + RP_W'(1);
    if (!push_held || (|press_stb) || rpt_fire) begin
      rpt_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rpt_cnt_q <= '0;
    end else begin
      rpt_cnt_q <= rpt_cnt_d;
    end
  end

  assign push_evt = press_stb[BTN_PUSH] | rpt_fire;
`else
  assign push_evt = press_stb[BTN_PUSH];
`endif

  // ---------------------------------------------------------------------------
  // Action select: clr > del > push; losers in the same cycle are dropped
  // ---------------------------------------------------------------------------
  typedef enum logic [1:0] {
    ACT_NONE,
    ACT_PUSH,
    ACT_DEL,
    ACT_CLR
  } action_e;

  action_e action;

  always_comb begin
    action = ACT_NONE;
    if (press_stb[BTN_CLR]) begin
      action = ACT_CLR;
    end else if (press_stb[BTN_DEL]) begin
      action = ACT_DEL;
    end else if (push_evt) begin
      action = ACT_PUSH;
    end
  end

  // ---------------------------------------------------------------------------
  // Entry register, digit count and overflow flag
  // ---------------------------------------------------------------------------
  logic [31:0] value_q;
  logic [31:0] value_d;
  logic [3:0]  count_q;
  logic [3:0]  count_d;
  logic        ovf_q;
  logic        ovf_d;
  logic        is_full;

  assign is_full = (count_q == 4'd8);

  always_comb begin
    value_d = value_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    case (action)
      ACT_CLR: begin
        value_d = '0;
        count_d = '0;
        ovf_d   = 1'b0;
      end
      ACT_DEL: begin
        if (count_q != 4'd0) begin
          value_d = {4'h0, value_q[31:4]};
          count_d = count_q - 4'd1;
        end
      end
      ACT_PUSH: begin
        if (is_full) begin
          ovf_d = 1'b1;
        end else begin
          // A zero digit still counts as an entry even though the value
          // does not change numerically.
          value_d = {value_q[27:0], dig_sync2_q};
          count_d = count_q + 4'd1;
        end
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value_q <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      value_q <= value_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  assign register    = value_q;
  assign digit_count = count_q;
  assign full        = is_full;
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_hex_entry_register.sv
module tb_hex_entry_register;

  localparam int DB = 4;
  localparam int RP = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  digit_in = 4'h0;
  logic        push_n = 1'b1;
  logic        del_n = 1'b1;
  logic        clr_n = 1'b1;
  logic [31:0] register;
  logic [3:0]  digit_count;
  logic        full;
  logic        overflow;

  hex_entry_register #(
    .DEBOUNCE_CYCLES(DB),
    .REPEAT_CYCLES  (RP)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .digit_in   (digit_in),
    .push_n     (push_n),
    .del_n      (del_n),
    .clr_n      (clr_n),
    .register   (register),
    .digit_count(digit_count),
    .full       (full),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // ---------------------------------------------------------------------------
  // Reference model: the entry is a queue of digits; a button is "pressed" once
  // the last DB synchronized samples all disagree with its debounced level.
  // ---------------------------------------------------------------------------
  bit         m_hist [3][8];   // raw button samples, index 0 = most recent edge
  logic [3:0] m_dhist [8];     // raw digit samples
  bit         m_stable [3];
  bit         m_pend [3];
  bit         m_rpt_pend;
  bit         m_all_diff;
  bit         m_rpt;
  int         m_cycle;
  int         m_last_clear;
  int         m_digs[$];
  bit         m_ovf;
  logic [2:0] m_raw;

  function automatic logic [31:0] m_value();
    logic [31:0] v = 32'h0;
    foreach (m_digs[i]) v = (v << 4) | 32'(m_digs[i]);
    return v;
  endfunction

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        for (int b = 0; b < 3; b++) begin
          for (int k = 0; k < 8; k++) m_hist[b][k] = 1'b1;
          m_stable[b] = 1'b1;
          m_pend[b]   = 1'b0;
        end
        for (int k = 0; k < 8; k++) m_dhist[k] = 4'h0;
        m_rpt_pend   = 1'b0;
        m_cycle      = 0;
        m_last_clear = 0;
        m_digs.delete();
        m_ovf = 1'b0;
      end else begin
        m_cycle++;
        m_raw = {clr_n, del_n, push_n};
        for (int b = 0; b < 3; b++) begin
          for (int k = 7; k > 0; k--) m_hist[b][k] = m_hist[b][k-1];
          m_hist[b][0] = m_raw[b];
        end
        for (int k = 7; k > 0; k--) m_dhist[k] = m_dhist[k-1];
        m_dhist[0] = digit_in;
        // actions requested in the previous cycle land on this edge
        if (m_pend[2]) begin
          m_digs.delete();
          m_ovf = 1'b0;
        end else if (m_pend[1]) begin
          if (m_digs.size() > 0) void'(m_digs.pop_back());
        end else if (m_pend[0] || m_rpt_pend) begin
          if (m_digs.size() < 8) m_digs.push_back(int'(m_dhist[2]));
          else m_ovf = 1'b1;
        end
        // debounced level for the cycle starting now
        for (int b = 0; b < 3; b++) begin
          m_all_diff = 1'b1;
          for (int k = 2; k <= DB + 1; k++)
            if (m_hist[b][k] == m_stable[b]) m_all_diff = 1'b0;
          m_pend[b] = 1'b0;
          if (m_all_diff) begin
            m_stable[b] = ~m_stable[b];
            m_pend[b]   = !m_stable[b];
          end
        end
`ifdef HOLD_REPEAT_EN
        m_rpt = !m_stable[0] && ((m_cycle - m_last_clear) == RP);
        if (m_stable[0] || m_pend[0] || m_pend[1] || m_pend[2] || m_rpt) m_last_clear = m_cycle;
        m_rpt_pend = m_rpt;
`else
        m_rpt_pend = 1'b0;
`endif
      end
    end
  end

  // Continuous comparison against the model on the falling edge.
  logic [39:0] chk_act;
  logic [39:0] chk_exp;
  initial begin
    forever begin
      @(negedge clk);
      chk_act = {register, digit_count, full, overflow, 2'b00};
      chk_exp = {m_value(), 4'(m_digs.size()), (m_digs.size() == 8), m_ovf, 2'b00};
      check("model", 64'(chk_act), 64'(chk_exp));
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers (all called while sitting just after a falling edge)
  // ---------------------------------------------------------------------------
  task automatic set_btn(input int b, input logic v);
    case (b)
      0:       push_n = v;
      1:       del_n  = v;
      default: clr_n  = v;
    endcase
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input int b, input logic [3:0] d, input int hold, input int rel);
    digit_in = d;
    set_btn(b, 1'b0);
    repeat (hold) @(negedge clk);
    set_btn(b, 1'b1);
    repeat (rel) @(negedge clk);
  endtask

  // Push with the update landing exactly on the 7th rising edge after the fall.
  task automatic press_timed(input logic [3:0] d, input logic [3:0] cnt_before, input logic [3:0] cnt_after);
    digit_in = d;
    push_n   = 1'b0;
    repeat (6) @(posedge clk);
    #1 check("lat6_count", 64'(digit_count), 64'(cnt_before));
    @(posedge clk);
    #1 check("lat7_count", 64'(digit_count), 64'(cnt_after));
    repeat (3) @(negedge clk);
    push_n = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  task automatic random_hold(input int b, input int hold, input int rel);
    set_btn(b, 1'b0);
    repeat (hold) begin
      @(negedge clk);
      digit_in = 4'($urandom);
    end
    set_btn(b, 1'b1);
    repeat (rel) begin
      @(negedge clk);
      digit_in = 4'($urandom);
    end
  endtask

  task automatic check_outputs(input string tag, input logic [31:0] r, input logic [3:0] c,
                               input logic f, input logic o);
    check({tag, "_register"}, 64'(register), 64'(r));
    check({tag, "_count"},    64'(digit_count), 64'(c));
    check({tag, "_full"},     64'(full), 64'(f));
    check({tag, "_overflow"}, 64'(overflow), 64'(o));
  endtask

  typedef struct {
    logic [3:0]  digit;
    int          btn;
    logic [31:0] exp_reg;
    logic [3:0]  exp_cnt;
    logic        exp_full;
    logic        exp_ovf;
  } vec_t;

  vec_t tbl[11];

  initial begin
    logic [3:0]  prev_cnt;
    logic [31:0] exp_hold_reg;
    logic [3:0]  exp_hold_cnt;
    int          sel;

    tbl[0]  = '{4'h1, 0, 32'h00000001, 4'd1, 1'b0, 1'b0};
    tbl[1]  = '{4'h2, 0, 32'h00000012, 4'd2, 1'b0, 1'b0};
    tbl[2]  = '{4'h3, 0, 32'h00000123, 4'd3, 1'b0, 1'b0};
    tbl[3]  = '{4'h4, 0, 32'h00001234, 4'd4, 1'b0, 1'b0};
    tbl[4]  = '{4'h5, 0, 32'h00012345, 4'd5, 1'b0, 1'b0};
    tbl[5]  = '{4'h6, 0, 32'h00123456, 4'd6, 1'b0, 1'b0};
    tbl[6]  = '{4'h7, 0, 32'h01234567, 4'd7, 1'b0, 1'b0};
    tbl[7]  = '{4'h8, 0, 32'h12345678, 4'd8, 1'b1, 1'b0};
    tbl[8]  = '{4'hF, 0, 32'h12345678, 4'd8, 1'b1, 1'b1};
    tbl[9]  = '{4'h0, 1, 32'h01234567, 4'd7, 1'b0, 1'b1};
    tbl[10] = '{4'h0, 2, 32'h00000000, 4'd0, 1'b0, 1'b0};

    // Reset and idle
    idle(3);
    rst_n = 1'b1;
    idle(20);
    check_outputs("reset", 32'h0, 4'd0, 1'b0, 1'b0);

    // Table: fill, overflow, delete, clear
    prev_cnt = 4'd0;
    for (int i = 0; i < 11; i++) begin
      if (tbl[i].btn == 0) press_timed(tbl[i].digit, prev_cnt, tbl[i].exp_cnt);
      else press(tbl[i].btn, tbl[i].digit, 10, 10);
      check_outputs($sformatf("tbl%0d", i), tbl[i].exp_reg, tbl[i].exp_cnt, tbl[i].exp_full, tbl[i].exp_ovf);
      prev_cnt = tbl[i].exp_cnt;
    end

    // Bounce: three 3-cycle lows with 2-cycle highs, then a steady low
    repeat (3) begin
      push_n = 1'b0;
      repeat (3) @(negedge clk);
      push_n = 1'b1;
      repeat (2) @(negedge clk);
    end
    press_timed(4'h3, 4'd0, 4'd1);
    check_outputs("bounce", 32'h3, 4'd1, 1'b0, 1'b0);

    // clr and push debounce together: clr wins
    clr_n  = 1'b0;
    push_n = 1'b0;
    digit_in = 4'h5;
    idle(10);
    clr_n  = 1'b1;
    push_n = 1'b1;
    idle(10);
    check_outputs("clr_push", 32'h0, 4'd0, 1'b0, 1'b0);

    // Reset in the middle of a debounce
    press(0, 4'h9, 10, 10);
    check_outputs("pre_rst", 32'h9, 4'd1, 1'b0, 1'b0);
    push_n = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    #1 check_outputs("async_rst", 32'h0, 4'd0, 1'b0, 1'b0);
    push_n = 1'b1;
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;
    idle(20);
    check_outputs("post_rst", 32'h0, 4'd0, 1'b0, 1'b0);

    // Long hold with digit A
`ifdef HOLD_REPEAT_EN
    exp_hold_reg = 32'h0000AAAA;
    exp_hold_cnt = 4'd4;
`else
    exp_hold_reg = 32'h0000000A;
    exp_hold_cnt = 4'd1;
`endif
    press(0, 4'hA, 60, 20);
    check_outputs("hold", exp_hold_reg, exp_hold_cnt, 1'b0, 1'b0);
    press(2, 4'h0, 10, 10);

    // Digit 0 still counts as an entry
    press(0, 4'h0, 10, 10);
    check_outputs("zero_digit", 32'h0, 4'd1, 1'b0, 1'b0);

    // Randomized traffic checked by the model
    for (int n = 0; n < 300; n++) begin
      sel = $urandom_range(0, 9);
      if (sel <= 5) begin
        random_hold(0, (sel == 5) ? $urandom_range(30, 50) : $urandom_range(1, 12), $urandom_range(1, 12));
      end else if (sel <= 7) begin
        random_hold(1, $urandom_range(1, 12), $urandom_range(1, 12));
      end else if (sel == 8) begin
        random_hold(2, $urandom_range(1, 12), $urandom_range(1, 12));
      end else begin
        repeat ($urandom_range(3, 10)) begin
          push_n   = 1'($urandom);
          del_n    = 1'($urandom);
          clr_n    = 1'($urandom);
          digit_in = 4'($urandom);
          @(negedge clk);
        end
        push_n = 1'b1;
        del_n  = 1'b1;
        clr_n  = 1'b1;
        idle(12);
      end
    end
    idle(12);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/hex_entry_register.md
Name: hex_entry_register

Overview:
- Upstream producer of the 32-bit value consumed by the 8-digit hex display stage.
- The operator keys in hex digits from 4 switches using three push-buttons: push, delete and clear.
- Each button is synchronized, debounced and edge-detected, so one press produces exactly one action.
- The accumulated value is shifted nibble-wise into a 32-bit register that drives the display stage directly.

Parameters:
- DEBOUNCE_CYCLES, default 1000000: consecutive cycles a synchronized button level must differ from its stable state before the stable state flips (20 ms at 50 MHz).
- REPEAT_CYCLES, default 25000000: hold time between auto-repeat pushes. Used only with HOLD_REPEAT_EN.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- digit_in  input  4  hex digit from switches; asynchronous to clk.
- push_n  input  1  active-low button; append digit_in.
- del_n  input  1  active-low button; remove last digit.
- clr_n  input  1  active-low button; clear all.
- register  output  32  entered value; bits [3:0] hold the most recent digit.
- digit_count  output  4  number of digits entered, 0..8.
- full  output  1  high when digit_count == 8.
- overflow  output  1  sticky; push attempted while full.

Behaviour:
- Reset: asynchronous; all state clears immediately.
  - register = 0, digit_count = 0, full = 0, overflow = 0.
  - Synchronizer flops reset to released (1); stable states reset to released; debounce counters reset to 0.
- Synchronizers: digit_in[3:0], push_n, del_n and clr_n each pass through a 2-flop synchronizer. s_x denotes the synchronized level.
- Debounce, per button:
  - Counter clears whenever s_x == stable_x.
  - When s_x != stable_x, the counter increments each cycle.
  - On the cycle the counter equals DEBOUNCE_CYCLES-1 with s_x != stable_x: stable_x <= s_x and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES cycles never changes stable_x.
- Press event: a 1-cycle strobe when stable_x goes 1 -> 0. Release produces no event.
- Latency: 2 edges of synchronization + DEBOUNCE_CYCLES edges of debounce + 1 edge to the register update.
- Actions on a strobe. Priority is clr > del > push; lower-priority strobes in the same cycle are discarded.
  - clr: register = 0, digit_count = 0, overflow = 0.
  - del, digit_count > 0: register = {4'h0, register[31:4]}; digit_count -= 1.
  - del, digit_count == 0: no change.
  - push, digit_count < 8: register = {register[27:0], s_digit}; digit_count += 1. s_digit is the synchronized digit sampled in the strobe cycle.
  - push, digit_count == 8: register unchanged; overflow = 1.
- full is combinational from digit_count.
- All outputs are registered except full.
- Holding a button produces exactly one event; the button must release (debounced) before it can produce another.
- A button held through reset deassertion registers one press after the debounce latency.
- Digit value 0 is a legal entry: it increments digit_count even though register is unchanged numerically.

Optional Feature:
- Macro: HOLD_REPEAT_EN.
- Defined:
  - While stable_push is pressed, a repeat counter runs from the press strobe.
  - Every REPEAT_CYCLES cycles it issues an additional push strobe, with the same rules as a press, including overflow when full.
  - The counter clears on release, on any del or clr strobe, and on reset.
  - del and clr never repeat.
- Undefined: no repeat logic; one push per press.

Test Plan:
- Bench parameters DEBOUNCE_CYCLES=4, REPEAT_CYCLES=16.
- Reset then idle 20 cycles -> register=0, digit_count=0, full=0, overflow=0.
- Press push 8 times with digit_in = 1,2,...,8, each held 10 cycles and released 10 cycles -> register=32'h12345678, digit_count=8, full=1; each update occurs exactly 7 edges after the push_n fall.
- At full, press push with digit_in=F -> register still 32'h12345678, overflow=1; then press del -> register=32'h01234567, digit_count=7, overflow stays 1; then press clr -> all zero.
- push_n bounce of 3-cycle low pulses separated by 2-cycle highs, then a steady low -> exactly one push event, after the steady low persists 4 cycles.
- Debounced strobes for clr and push landing in the same cycle -> register=0, digit_count=0. rst_n asserted mid-debounce -> outputs zero immediately, with no spurious event after release.
- With HOLD_REPEAT_EN defined, hold push 60 cycles with digit_in=A -> register=32'h0000AAAA, digit_count=4 (1 press + 3 repeats); without the macro -> register=32'h0000000A.
